// File: rtl/dbg_bus_pkg.sv
// Shared types and default parameters for the debug bus master.
package dbg_bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_LEN_WIDTH      = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned ERR_COUNT_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WD = 2'd1,
    ST_BUS     = 2'd2,
    ST_RESP    = 2'd3
  } dbg_state_t;

  // Saturating increment for the timeout error counter.
  function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(input logic [ERR_COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + ERR_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dbg_bus_master_if.sv
// Request / write-data / response streams plus target bus of the debug bus master.
interface dbg_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = dbg_bus_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = dbg_bus_pkg::DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = dbg_bus_pkg::DEF_LEN_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_incr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_last;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_incr, req_addr, req_len, wd_valid, wd_data,
           rsp_ready, bus_ack, bus_rdata,
    output req_ready, wd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_incr, req_addr, req_len, wd_valid, wd_data,
           rsp_ready, bus_ack, bus_rdata,
    input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_err, rsp_last,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dbg_timeout_counter.sv
// Counts cycles a bus request waits for ack; flags expiry on the TIMEOUT_CYCLES-th cycle.
module dbg_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = dbg_bus_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetb,
  input  logic i_start,     // high while no request is pending; count restarts from zero
  input  logic i_ack,
  output logic o_expired_c
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                        r_cnt <= '0;
    else if (i_start)                   r_cnt <= '0;
    else if (!i_ack && (r_cnt != LIMIT)) r_cnt <= r_cnt + CNT_W'(1);
  end

  // An ack in the expiry cycle wins over the timeout.
  assign o_expired_c = !i_start && !i_ack && (r_cnt == LIMIT);

endmodule

// File: rtl/dbg_bus_master.sv
// Debug bus master: turns burst request headers into single-beat target bus accesses.
module dbg_bus_master #(
  parameter int unsigned ADDR_WIDTH     = dbg_bus_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = dbg_bus_pkg::DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH      = dbg_bus_pkg::DEF_LEN_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = dbg_bus_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic                                    clk,
  input  logic                                    resetb,
  dbg_bus_master_if.master                        bus_if,
  output logic                                    busy,
  output logic [dbg_bus_pkg::ERR_COUNT_WIDTH-1:0] err_count
);
  import dbg_bus_pkg::*;

  dbg_state_t                 r_state;
  logic                       r_incr;
  logic                       r_skip;
  logic                       r_werr;
  logic [LEN_WIDTH-1:0]       r_cnt;
  logic                       r_req_ready;
  logic                       r_wd_ready;
  logic                       r_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_data;
  logic                       r_rsp_err;
  logic                       r_rsp_last;
  logic                       r_bus_req;
  logic                       r_bus_we;
  logic [ADDR_WIDTH-1:0]      r_bus_addr;
  logic [DATA_WIDTH-1:0]      r_bus_wdata;
  logic                       r_busy;
  logic [ERR_COUNT_WIDTH-1:0] r_err_count;

  logic                  w_req_fire;
  logic                  w_wd_fire;
  logic                  w_rsp_fire;
  logic                  w_ack;
  logic                  w_tmo;
  logic                  w_tmo_start;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_cnt_dec;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  assign w_req_fire  = bus_if.req_valid & r_req_ready;
  assign w_wd_fire   = bus_if.wd_valid & r_wd_ready;
  assign w_rsp_fire  = r_rsp_valid & bus_if.rsp_ready;
  assign w_ack       = r_bus_req & bus_if.bus_ack;
  assign w_tmo_start = ~r_bus_req;
  assign w_last      = (r_cnt == '0);
  assign w_cnt_dec   = r_cnt - LEN_WIDTH'(1);
  assign w_addr_next = r_incr ? (r_bus_addr + ADDR_WIDTH'(1)) : r_bus_addr;

  dbg_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk         (clk),
    .resetb      (resetb),
    .i_start     (w_tmo_start),
    .i_ack       (bus_if.bus_ack),
    .o_expired_c (w_tmo)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_IDLE;
      r_incr      <= 1'b0;
      r_skip      <= 1'b0;
      r_werr      <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_wd_ready  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_busy      <= 1'b0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_bus_we    <= bus_if.req_we;
            r_incr      <= bus_if.req_incr;
            r_bus_addr  <= bus_if.req_addr;
            r_cnt       <= bus_if.req_len;
            r_skip      <= 1'b0;
            r_werr      <= 1'b0;
            if (bus_if.req_we) begin
              r_wd_ready <= 1'b1;
              r_state    <= ST_WAIT_WD;
            end else begin
              r_bus_req <= 1'b1;
              r_state   <= ST_BUS;
            end
          end
        end

        // After a timeout, write data is still drained but never reaches the bus.
        ST_WAIT_WD: begin
          if (w_wd_fire) begin
            r_bus_wdata <= bus_if.wd_data;
            if (!r_skip) begin
              r_wd_ready <= 1'b0;
              r_bus_req  <= 1'b1;
              r_state    <= ST_BUS;
            end else if (w_last) begin
              r_wd_ready  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= r_werr;
              r_rsp_last  <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_cnt      <= w_cnt_dec;
              r_bus_addr <= w_addr_next;
            end
          end
        end

        ST_BUS: begin
          if (w_ack || w_tmo) begin
            r_bus_req <= 1'b0;
            if (w_tmo) begin
              r_skip      <= 1'b1;
              r_err_count <= sat_inc(r_err_count);
            end
            if (!w_last) begin
              r_cnt      <= w_cnt_dec;
              r_bus_addr <= w_addr_next;
            end
            if (r_bus_we) begin
              r_werr <= r_werr | w_tmo;
              if (w_last) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_err   <= r_werr | w_tmo;
                r_rsp_last  <= 1'b1;
                r_state     <= ST_RESP;
              end else begin
                r_wd_ready <= 1'b1;
                r_state    <= ST_WAIT_WD;
              end
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_tmo ? '0 : bus_if.bus_rdata;
              r_rsp_err   <= w_tmo;
              r_rsp_last  <= w_last;
              r_state     <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            if (r_bus_we || r_rsp_last) begin
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end else if (r_skip) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_last  <= w_last;
              if (!w_last) begin
                r_cnt      <= w_cnt_dec;
                r_bus_addr <= w_addr_next;
              end
            end else begin
              r_bus_req <= 1'b1;
              r_state   <= ST_BUS;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.req_ready = r_req_ready;
  assign bus_if.wd_ready  = r_wd_ready;
  assign bus_if.rsp_valid = r_rsp_valid;
  assign bus_if.rsp_data  = r_rsp_data;
  assign bus_if.rsp_err   = r_rsp_err;
  assign bus_if.rsp_last  = r_rsp_last;
  assign bus_if.bus_req   = r_bus_req;
  assign bus_if.bus_we    = r_bus_we;
  assign bus_if.bus_addr  = r_bus_addr;
  assign bus_if.bus_wdata = r_bus_wdata;
  assign busy             = r_busy;
  assign err_count        = r_err_count;

endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: Dbg_bus_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: bus/request address width in words.
REQ-002 Parameter DATA_WIDTH, default 32: bus/request data width.
REQ-003 Parameter LEN_WIDTH, default 8: burst length field width; beats = len+1.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: max cycles bus_req may wait for bus_ack.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 resetb  in  1  asynchronous active-low reset.
REQ-007 req_valid/req_ready  in/out  1/1  request header handshake.
REQ-008 req_we, req_incr  in  1,1  write burst; auto-increment address (0 = fixed address).
REQ-009 req_addr, req_len  in  ADDR_WIDTH, LEN_WIDTH  start word address, beats-1.
REQ-010 wd_valid/wd_ready, wd_data  in/out, in  1/1, DATA_WIDTH  write-data stream.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_data, rsp_err, rsp_last  out  DATA_WIDTH,1,1  read data or 0; error; final beat.
REQ-013 bus_req, bus_we, bus_addr, bus_wdata  out  1,1,ADDR_WIDTH,DATA_WIDTH  target bus.
REQ-014 bus_ack, bus_rdata  in  1, DATA_WIDTH  one-cycle ack; rdata valid with ack.
REQ-015 busy, err_count  out  1, 8  burst in progress; saturating timeout count.

Function
REQ-016 Any handshake completes on a clk edge with valid and ready both high.
REQ-017 FSM states IDLE, WAIT_WD, BUS, RESP; req_ready=1 only in IDLE; busy=1 outside IDLE.
REQ-018 IDLE+header accepted: latch we/incr/addr/len, beat counter=len; go WAIT_WD if we else BUS.
REQ-019 WAIT_WD: wd_ready=1; on accept latch wd_data into bus_wdata, go BUS next cycle.
REQ-020 BUS: bus_req=1 with bus_addr/bus_we/bus_wdata held stable until bus_ack sampled or timeout.
REQ-021 Read latency: header accepted cycle N -> bus_req high cycle N+1; rdata captured on ack cycle.
REQ-022 After each beat: counter==0 -> last; else counter-1, addr+1 mod 2^ADDR_WIDTH if incr, else unchanged.
REQ-023 Reads: every beat enters RESP with rsp_data=captured rdata, rsp_last=(counter==0); RESP holds until rsp_ready.
REQ-024 Writes: no per-beat response; one RESP after final beat, rsp_data=0, rsp_last=1, rsp_err=OR of beat errors.
REQ-025 After read RESP accepted: next beat -> BUS, after last -> IDLE; after write RESP -> IDLE.
REQ-026 Timeout: wait counter reset at bus_req assert; bus_ack not seen for TIMEOUT_CYCLES cycles -> drop bus_req next cycle, beat error, err_count+1 saturating at 255.
REQ-027 After timeout, remaining beats skip bus: reads emit rsp_data=0 rsp_err=1 per beat; writes still drain remaining wd words.
REQ-028 bus_ack arriving in the same cycle timeout expires counts as success.
REQ-029 bus_ack while bus_req=0 is ignored.
REQ-030 Address wrap at max address is silent, no error.

Reset
REQ-031 resetb low asynchronously forces IDLE, bus_req=0, rsp_valid=0, wd_ready=0, req_ready=0 while low, busy=0, err_count=0, all data/address outputs 0.
REQ-032 Reset mid-burst abandons the burst; no response emitted; req_ready=1 first edge after release.

Structure
REQ-033 Package Dbg_bus_pkg holds state typedef Dbg_state_t and default parameter constants.
REQ-034 Sub-module Dbg_timeout_counter (start, ack, expired, width from TIMEOUT_CYCLES) implements REQ-026.

Verification
REQ-035 Read burst addr 0x1000 len 15 incr=1, ack 2 cycles after req -> 16 responses, addrs 0x1000..0x100F, last on 16th.
REQ-036 Write burst addr 0x20 len 3 incr=0, data 0xA..0xD -> 4 bus writes all at 0x20, one response err=0 last=1.
REQ-037 Read addr 0xFFFFFFFF len 1 incr=1 -> bus addrs 0xFFFFFFFF then 0x00000000, no error.
REQ-038 Read len 2, target never acks -> 3 responses data 0 err=1, err_count=1, bus_req low after 255 cycles.
REQ-039 rsp_ready held low 10 cycles mid-read-burst -> rsp stable, no new bus_req until accepted.
REQ-040 resetb pulsed low during beat 2 of write len 4 -> outputs reset immediately, new read 0x0 completes normally.
